silife_sequencer: RTL and testbench
===================================

SILIFE_SEQUENCER -- requirements
Module: silife_sequencer

Interface
REQ-001 Parameter STEP_PERIOD_W, default 16, width of generation period and counter.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_run  in  1  free-running generation stepping enabled.
REQ-005 i_single_step  in  1  level input; rising edge requests exactly one generation.
REQ-006 i_period  in  STEP_PERIOD_W  clocks between generations while running; 0 treated as 1.
REQ-007 i_host_req / i_host_row[4:0] / i_host_cells[7:0]  in  host row-write request, row, data.
REQ-008 o_host_ack  out  1  one-cycle pulse when host write is applied to grid.
REQ-009 i_demo_req / i_demo_row[4:0] / i_demo_cells[7:0]  in  demo-loader row-write request, row, data.
REQ-010 o_demo_ack  out  1  one-cycle pulse when demo write is applied.
REQ-011 o_row_select  out  5  grid write row; o_set_cells / o_clear_cells  out  8 each, grid set/clear masks.
REQ-012 o_step  out  1  one-cycle grid enable pulse = one generation.
REQ-013 o_gen_count  out  STEP_PERIOD_W  generations completed, wraps.
REQ-014 o_busy  out  1  high while any step or write is pending.

Function
REQ-015 Single shared grid port; per cycle exactly one of: step, host write, demo write, idle.
REQ-016 FSM states IDLE, WRITE, STEP; outputs registered; one grant per cycle; return to IDLE after each grant unless further request pending (back-to-back grants allowed).
REQ-017 Timer: counts clocks while i_run=1; on reaching max(i_period,1)-1 sets step_pending and restarts at 0; held at 0 while i_run=0.
REQ-018 Rising edge of i_single_step sets step_pending regardless of i_run; edge while pending already set is absorbed (no double step).
REQ-019 Priority: step_pending over writes, except the cycle immediately after an o_step pulse, when a pending write wins (no write starvation at period 1).
REQ-020 Between writers: round-robin; last-granted writer loses a tie; first tie after reset goes to host.
REQ-021 Request sampled cycle N -> grant outputs and ack in cycle N+1; requester holds req/row/cells stable until ack; req deasserted before ack is dropped silently.
REQ-022 Write grant: o_set_cells=cells, o_clear_cells=~cells, o_row_select=row for one cycle; otherwise both masks 0, o_row_select=0.
REQ-023 Step grant: o_step=1 one cycle, masks 0, step_pending cleared, o_gen_count increments same cycle, wraps all-ones -> 0.
REQ-024 i_period change takes effect at next timer restart; if counter already >= new period-1, restart at next clock.
REQ-025 o_busy = step_pending | host_req | demo_req, registered.

Reset
REQ-026 rst_n low: all outputs 0, FSM IDLE, timer 0, step_pending 0, round-robin pointer to host, single-step edge detector primed so a level held high through reset is not an edge.
REQ-027 Reset mid-write or mid-step aborts it; no ack or step issued after reset release until new request.

Configuration
REQ-028 Macro SILIFE_GEN_COUNTER_EN: defined -> o_gen_count per REQ-023; undefined -> counter removed, o_gen_count tied 0, all other behaviour identical.

Structure
REQ-029 Package silife_pkg: GRID_WIDTH=8, GRID_HEIGHT=32, ROW_BITS=5, sequencer state enum.
REQ-030 Sub-module silife_step_timer holds period counter and single-step edge detect, outputs step_request pulse.

Verification
REQ-031 i_run=1, i_period=4, no writes -> o_step every 4th clock; after 10 steps o_gen_count=10.
REQ-032 i_run=0, i_single_step high 5 clocks -> exactly one o_step; o_gen_count +1.
REQ-033 Host and demo req together, rows 3 and 7, cells 0xA5/0x3C -> host ack first (row 3, set 0xA5, clear 0x5A), demo ack next cycle (row 7, set 0x3C, clear 0xC3).
REQ-034 i_period=1, i_run=1, host req held -> host ack within 2 clocks of request; steps continue alternating.
REQ-035 rst_n low during pending write and step -> all outputs 0 immediately; after release no ack/step without new request.
REQ-036 Build without SILIFE_GEN_COUNTER_EN, repeat REQ-031 -> identical o_step timing, o_gen_count stays 0.

Source files
------------

// File: rtl/silife_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | silife_pkg : grid geometry and sequencer state encoding            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package silife_pkg;

  localparam int GRID_WIDTH  = 8;
  localparam int GRID_HEIGHT = 32;
  localparam int ROW_BITS    = $clog2(GRID_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STEP  = 2'd2
  } seq_state_e;

  typedef enum logic {
    WR_HOST = 1'b0,
    WR_DEMO = 1'b1
  } writer_e;

endpackage
`default_nettype wire

// File: rtl/silife_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | silife_step_timer : generation period counter + single-step edge   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module silife_step_timer #(
  parameter int STEP_PERIOD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_run,
  input  logic                     i_single_step,
  input  logic [STEP_PERIOD_W-1:0] i_period,
  output logic                     o_step_request
);

  logic [STEP_PERIOD_W-1:0] count_q, count_d;
  logic [STEP_PERIOD_W-1:0] last_tick;
  logic                     single_prev_q, single_prev_d;
  logic                     fire;

  always_comb begin
    last_tick     = (i_period == '0) ? '0 : i_period - STEP_PERIOD_W'(1);
    fire          = 1'b0;
    count_d       = count_q;
    single_prev_d = i_single_step;
    // A shortened period that the count already passed restarts on the next clock.
    if (!i_run) begin
      count_d = '0;
    end else if (count_q >= last_tick) begin
      count_d = '0;
      fire    = 1'b1;
    end else begin
      count_d = count_q + STEP_PERIOD_W'(1);
    end
  end

  // Edge detector resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      single_prev_q <= 1'b1;
    end else begin
      count_q       <= count_d;
      single_prev_q <= single_prev_d;
    end
  end

  assign o_step_request = fire | (i_single_step & ~single_prev_q);

endmodule
`default_nettype wire

// File: rtl/silife_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | silife_sequencer : arbitrates generation steps and row writes onto |
// | the grid port; SILIFE_GEN_COUNTER_EN enables o_gen_count. rev 1.0  |
// +--------------------------------------------------------------------+
module silife_sequencer
  import silife_pkg::*;
#(
  parameter int STEP_PERIOD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_run,
  input  logic                     i_single_step,
  input  logic [STEP_PERIOD_W-1:0] i_period,
  input  logic                     i_host_req,
  input  logic [ROW_BITS-1:0]      i_host_row,
  input  logic [GRID_WIDTH-1:0]    i_host_cells,
  output logic                     o_host_ack,
  input  logic                     i_demo_req,
  input  logic [ROW_BITS-1:0]      i_demo_row,
  input  logic [GRID_WIDTH-1:0]    i_demo_cells,
  output logic                     o_demo_ack,
  output logic [ROW_BITS-1:0]      o_row_select,
  output logic [GRID_WIDTH-1:0]    o_set_cells,
  output logic [GRID_WIDTH-1:0]    o_clear_cells,
  output logic                     o_step,
  output logic [STEP_PERIOD_W-1:0] o_gen_count,
  output logic                     o_busy
);

  seq_state_e              state_q, state_d;
  writer_e                 last_writer_q, last_writer_d;
  logic                    step_pending_q, step_pending_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [GRID_WIDTH-1:0]   set_q, set_d, clr_q, clr_d;
  logic                    host_ack_q, host_ack_d, demo_ack_q, demo_ack_d;
  logic                    busy_q, busy_d;
  logic                    step_request;
  logic                    host_ok, demo_ok, pick_demo, grant_step, grant_write;

  silife_step_timer #(.STEP_PERIOD_W(STEP_PERIOD_W)) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run          (i_run),
    .i_single_step  (i_single_step),
    .i_period       (i_period),
    .o_step_request (step_request)
  );

  always_comb begin
    // A requester still sees its ack this cycle; do not grant it twice.
    host_ok     = i_host_req & ~host_ack_q;
    demo_ok     = i_demo_req & ~demo_ack_q;
    pick_demo   = demo_ok & (~host_ok | (last_writer_q == WR_HOST));
    grant_step  = step_pending_q & ~((host_ok | demo_ok) & (state_q == ST_STEP));
    grant_write = (host_ok | demo_ok) & ~grant_step;

    state_d        = ST_IDLE;
    last_writer_d  = last_writer_q;
    row_d          = '0;
    set_d          = '0;
    clr_d          = '0;
    host_ack_d     = 1'b0;
    demo_ack_d     = 1'b0;
    step_pending_d = step_request | (step_pending_q & ~grant_step);
    busy_d         = step_pending_d | i_host_req | i_demo_req;

    if (grant_step) begin
      state_d = ST_STEP;
    end else if (grant_write) begin
      state_d = ST_WRITE;
      if (pick_demo) begin
        last_writer_d = WR_DEMO;
        demo_ack_d    = 1'b1;
        row_d         = i_demo_row;
        set_d         = i_demo_cells;
        clr_d         = ~i_demo_cells;
      end else begin
        last_writer_d = WR_HOST;
        host_ack_d    = 1'b1;
        row_d         = i_host_row;
        set_d         = i_host_cells;
        clr_d         = ~i_host_cells;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_writer_q  <= WR_DEMO;
      step_pending_q <= 1'b0;
      row_q          <= '0;
      set_q          <= '0;
      clr_q          <= '0;
      host_ack_q     <= 1'b0;
      demo_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_writer_q  <= last_writer_d;
      step_pending_q <= step_pending_d;
      row_q          <= row_d;
      set_q          <= set_d;
      clr_q          <= clr_d;
      host_ack_q     <= host_ack_d;
      demo_ack_q     <= demo_ack_d;
      busy_q         <= busy_d;
    end
  end

  assign o_step        = (state_q == ST_STEP);
  assign o_host_ack    = host_ack_q;
  assign o_demo_ack    = demo_ack_q;
  assign o_row_select  = row_q;
  assign o_set_cells   = set_q;
  assign o_clear_cells = clr_q;
  assign o_busy        = busy_q;

`ifdef SILIFE_GEN_COUNTER_EN
  logic [STEP_PERIOD_W-1:0] gen_q, gen_d;

  always_comb begin
    gen_d = grant_step ? gen_q + STEP_PERIOD_W'(1) : gen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_q <= '0;
    else        gen_q <= gen_d;
  end

  assign o_gen_count = gen_q;
`else
  assign o_gen_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silife_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_silife_sequencer : scoreboard bench for silife_sequencer        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_silife_sequencer;

  localparam int W = 16;
`ifdef SILIFE_GEN_COUNTER_EN
  localparam bit GEN_ON = 1'b1;
`else
  localparam bit GEN_ON = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         i_run = 1'b0, i_single_step = 1'b0;
  logic [W-1:0] i_period = 16'd4;
  logic         i_host_req = 1'b0, i_demo_req = 1'b0;
  logic [4:0]   i_host_row = '0, i_demo_row = '0;
  logic [7:0]   i_host_cells = '0, i_demo_cells = '0;
  logic         o_host_ack, o_demo_ack, o_step, o_busy;
  logic [4:0]   o_row_select;
  logic [7:0]   o_set_cells, o_clear_cells;
  logic [W-1:0] o_gen_count;

  silife_sequencer #(.STEP_PERIOD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_single_step(i_single_step),
    .i_period(i_period),
    .i_host_req(i_host_req), .i_host_row(i_host_row), .i_host_cells(i_host_cells),
    .o_host_ack(o_host_ack),
    .i_demo_req(i_demo_req), .i_demo_row(i_demo_row), .i_demo_cells(i_demo_cells),
    .o_demo_ack(o_demo_ack),
    .o_row_select(o_row_select), .o_set_cells(o_set_cells), .o_clear_cells(o_clear_cells),
    .o_step(o_step), .o_gen_count(o_gen_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Event word: {kind, row, set, clear}; kind 1=step 2=host 3=demo.
  function automatic logic [31:0] ev(input logic [1:0] k, input logic [4:0] r, input logic [7:0] c);
    if (k == 2'd1) return {9'b0, k, 5'd0, 8'd0, 8'd0};
    return {9'b0, k, r, c, ~c};
  endfunction

  function automatic logic [31:0] exp_gen(input int n);
    return GEN_ON ? 32'(n) : 32'd0;
  endfunction

  logic [31:0] sb[$];
  int          cyc = 0, n_steps = 0, n_grants = 0, prev_step = 0, exp_intv = 0;
  bit          have_prev = 1'b0, chk_intv = 1'b0, free_steps = 1'b0;
  logic [1:0]  k_obs;
  logic [31:0] obs;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("one_grant_per_cycle", 32'($countones({o_step, o_host_ack, o_demo_ack}) <= 1), 32'd1);
      k_obs = o_demo_ack ? 2'd3 : o_host_ack ? 2'd2 : o_step ? 2'd1 : 2'd0;
      obs   = {9'b0, k_obs, o_row_select, o_set_cells, o_clear_cells};
      if (o_step) begin
        n_steps++;
        if (chk_intv && have_prev) check("step_interval", 32'(cyc - prev_step), 32'(exp_intv));
        have_prev = 1'b1;
        prev_step = cyc;
      end
      if (k_obs != 2'd0) begin
        n_grants++;
        if (!(k_obs == 2'd1 && free_steps)) begin
          if (sb.size() == 0) check("unexpected_grant", obs, 32'd0);
          else                check("grant", obs, sb.pop_front());
        end
      end
      if (o_host_ack) i_host_req = 1'b0;
      if (o_demo_ack) i_demo_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {27'b0, o_step, o_host_ack, o_demo_ack, o_busy, (o_row_select != 0)}, 32'd0);
    check({tag, "_masks"}, {16'b0, o_set_cells, o_clear_cells}, 32'd0);
    check({tag, "_gen"}, 32'(o_gen_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, lat, g0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Free-running at period 4: ten steps four clocks apart.
    base = n_steps;
    for (int i = 0; i < 10; i++) sb.push_back(ev(2'd1, 5'd0, 8'd0));
    have_prev = 1'b0; chk_intv = 1'b1; exp_intv = 4;
    i_period = 16'd4; i_run = 1'b1;
    for (int i = 0; i < 80 && n_steps < base + 10; i++) tick();
    i_run = 1'b0;
    chk_intv = 1'b0;
    check("run_step_count", 32'(n_steps - base), 32'd10);
    check("gen_after_run", 32'(o_gen_count), exp_gen(10));
    wait_drain("drain_run", 10);

    // Single step held high for five clocks yields exactly one step.
    sb.push_back(ev(2'd1, 5'd0, 8'd0));
    i_single_step = 1'b1;
    repeat (5) tick();
    i_single_step = 1'b0;
    repeat (10) tick();
    wait_drain("drain_single", 5);
    check("gen_after_single", 32'(o_gen_count), exp_gen(11));
    check("busy_idle", 32'(o_busy), 32'd0);

    // Simultaneous writers: host first after reset, then demo.
    sb.push_back(ev(2'd2, 5'd3, 8'hA5));
    sb.push_back(ev(2'd3, 5'd7, 8'h3C));
    i_host_row = 5'd3; i_host_cells = 8'hA5; i_demo_row = 5'd7; i_demo_cells = 8'h3C;
    i_host_req = 1'b1; i_demo_req = 1'b1;
    wait_drain("drain_tie1", 20);
    tick();
    // Host alone, then a tie: last-granted host must lose.
    sb.push_back(ev(2'd2, 5'd1, 8'h0F));
    i_host_row = 5'd1; i_host_cells = 8'h0F; i_host_req = 1'b1;
    wait_drain("drain_host_only", 20);
    tick();
    sb.push_back(ev(2'd3, 5'd4, 8'h81));
    sb.push_back(ev(2'd2, 5'd2, 8'hF0));
    i_host_row = 5'd2; i_host_cells = 8'hF0; i_demo_row = 5'd4; i_demo_cells = 8'h81;
    i_host_req = 1'b1; i_demo_req = 1'b1;
    wait_drain("drain_tie2", 20);
    tick();

    // Period 1 with host writes: writes still get through, steps interleave.
    free_steps = 1'b1;
    i_period = 16'd1; i_run = 1'b1;
    repeat (5) tick();
    for (int j = 0; j < 3; j++) begin
      sb.push_back(ev(2'd2, 5'(10 + j), 8'(8'h11 * j + 5)));
      i_host_row = 5'(10 + j); i_host_cells = 8'(8'h11 * j + 5); i_host_req = 1'b1;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!o_host_ack && lat < 6);
      check("host_ack_latency_le2", 32'(lat <= 2), 32'd1);
      tick();
      check("step_after_write", 32'(o_step), 32'd1);
    end
    i_run = 1'b0;
    repeat (5) tick();
    wait_drain("drain_period1", 5);

    // Period 0 behaves as period 1: a step every clock.
    i_period = 16'd0; i_run = 1'b1;
    repeat (4) tick();
    have_prev = 1'b0; chk_intv = 1'b1; exp_intv = 1;
    repeat (6) tick();
    chk_intv = 1'b0;
    i_run = 1'b0;
    repeat (5) tick();
    free_steps = 1'b0;

    // Reset with a write and a step pending; single-step held high through it.
    i_period = 16'd4;
    i_host_row = 5'd5; i_host_cells = 8'h99; i_demo_row = 5'd6; i_demo_cells = 8'h66;
    i_single_step = 1'b1; i_host_req = 1'b1; i_demo_req = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    i_host_req = 1'b0; i_demo_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    g0 = n_grants;
    repeat (12) tick();
    check("post_reset_quiet", 32'(n_grants - g0), 32'd0);
    check("post_reset_gen", 32'(o_gen_count), 32'd0);
    i_single_step = 1'b0;
    tick();
    sb.push_back(ev(2'd1, 5'd0, 8'd0));
    i_single_step = 1'b1;
    wait_drain("drain_after_reset", 10);
    tick();
    check("gen_after_reset_step", 32'(o_gen_count), exp_gen(1));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
